// File: rtl/encoder4_2_seq_if.sv
// Request/grant bundle for encoder4_2_seq: capture inputs, output slot handshake and status.
// The master drives requests and out_ready; the slave (the encoder) drives the code slot and status.
interface encoder4_2_seq_if;
  logic       en;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] y_code;
  logic [3:0] pending;
  logic       drop;

  modport master (
    output en, req, out_ready,
    input  out_valid, y_code, pending, drop
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, y_code, pending, drop
  );
endinterface

// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 encoder: request pulses collect in a pending register and drain one code per handshake.
// Define ENCODER4_2_SEQ_ROUND_ROBIN_EN for round-robin selection; the default is fixed priority, 3 highest.
module encoder4_2_seq (
  input  logic             clk,
  input  logic             rst_n,
  encoder4_2_seq_if.slave  bus
);

  logic [3:0] r_pending;
  logic       r_out_valid;
  logic [1:0] r_y_code;
  logic       r_drop;
`ifdef ENCODER4_2_SEQ_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
`endif

  logic       w_slot_free;
  logic       w_found;
  logic       w_load;
  logic [1:0] w_sel;
  logic [3:0] w_load_onehot;
  logic [3:0] w_req_masked;
  logic [3:0] w_pending_next;
  logic       w_drop_next;

  // Selection looks only at the registered pending bits, never at this cycle's req.
  always_comb begin : select_index
`ifdef ENCODER4_2_SEQ_ROUND_ROBIN_EN
    logic [1:0] w_idx;
`endif
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    w_sel   = 2'd0;
    w_found = 1'b0;
`ifdef ENCODER4_2_SEQ_ROUND_ROBIN_EN
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (r_pending[i]) begin
        w_sel   = 2'(i);
        w_found = 1'b1;
      end
    end
`endif
  end

  assign w_slot_free    = !r_out_valid || bus.out_ready;
  assign w_load         = w_slot_free && w_found;
  assign w_load_onehot  = w_load ? (4'b0001 << w_sel) : 4'b0000;
  assign w_req_masked   = bus.en ? bus.req : 4'b0000;
  assign w_pending_next = (r_pending & ~w_load_onehot) | w_req_masked;
  // A request on a bit that is being loaded this edge is a fresh event, not a merge.
  assign w_drop_next    = |(w_req_masked & r_pending & ~w_load_onehot);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      r_pending   <= 4'b0000;
      r_out_valid <= 1'b0;
      r_y_code    <= 2'b00;
      r_drop      <= 1'b0;
`ifdef ENCODER4_2_SEQ_ROUND_ROBIN_EN
      r_ptr       <= 2'd3;
`endif
    end else begin
      r_pending <= w_pending_next;
      r_drop    <= w_drop_next;
      if (w_slot_free) begin
        r_out_valid <= w_load;
        if (w_load) r_y_code <= w_sel;
      end
`ifdef ENCODER4_2_SEQ_ROUND_ROBIN_EN
      if (w_load) r_ptr <= w_sel;
`endif
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.y_code    = r_y_code;
  assign bus.pending   = r_pending;
  assign bus.drop      = r_drop;

endmodule
